data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the core data-memory interface. Serves data read/write requests from two cores over the Mem_Ctrl / DAddress / Ddout / Ddin / dacq handshake.
- Owns an 8-bit-wide data memory and arbitrates between the cores round-robin, one transaction at a time.
- Returns read data on Ddin and a one-cycle dacq pulse on completion.
- Sits at top level between the core instances and shared data storage.

Parameters:
- DEPTH, 256, number of 8-bit memory words; address bits above log2(DEPTH) are ignored.
- LAT, 2, cycles from request acceptance to dacq; legal range 1..15.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- Mem_Ctrl0  in  4  core 0 control: bit0 = data read, bit1 = data write, bits3:2 ignored.
- DAddress0  in  8  core 0 data address.
- Ddout0  in  8  core 0 write data.
- Ddin0  out  8  read data to core 0.
- dacq0  out  1  core 0 completion pulse.
- Mem_Ctrl1, DAddress1, Ddout1, Ddin1, dacq1: same as core 0 ports, for core 1.
- busy_mem  out  1  high whenever FSM is not IDLE.
- err  out  1  sticky; set when an accepted request has both read and write bits set.

Behaviour:
- Reset (RST=1 at an edge):
  - Ddin0 = Ddin1 = 0; dacq0 = dacq1 = 0; busy_mem = 0; err = 0.
  - FSM -> IDLE; counter = 0; last_grant = 1, so core 0 wins the first tie.
  - Memory contents are not cleared.
  - Reset mid-transaction aborts it: no write occurs and no dacq is issued.
- Request detection: port n is requesting when Mem_Ctrl_n[1:0] != 0.
- Core obligations: hold address, data and control stable until dacq_n is seen; deassert or change the request the cycle after dacq_n.
- FSM states: IDLE, WAIT, ACK, RECOVER.
- IDLE:
  - With no request, stay in IDLE.
  - Otherwise grant a port:
    - one requester: grant it;
    - both requesting: grant the port != last_grant.
  - Register grant, op, address and wdata. An op with both bits set is treated as a write and sets err.
  - Load counter = LAT-1, then:
    - LAT=1: go to ACK;
    - LAT>1: go to WAIT.
- WAIT: decrement counter; go to ACK when counter reaches 1 (in that same cycle).
- ACK (exactly one cycle):
  - Assert dacq for the granted port only.
  - Read: mem[addr] drives that port's Ddin in the same cycle as dacq.
  - Write: mem[addr] <= wdata at the end of the ACK cycle.
  - Update last_grant = grant; go to RECOVER.
- RECOVER: one cycle with no acceptance, so the core can drop its request; then go to IDLE.
- Timing:
  - A request sampled in IDLE at cycle t gives dacq at t+LAT.
  - Next acceptance is no earlier than t+LAT+2.
  - busy_mem is high from t+1 through t+LAT+1.
- Ddin_n holds its last read value until the next read completes for that port. Writes never change Ddin.
- The non-granted port sees no dacq. Its request stays pending and is granted in the next IDLE cycle.
- Read-after-write to the same address returns the new data, because the write commits at the end of ACK.
- Address wrap: the effective address is DAddress mod DEPTH.
- Request bits are sampled only in IDLE. Changes during WAIT, ACK or RECOVER are ignored until the next IDLE.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then all Mem_Ctrl=0 for 10 cycles -> Ddin0/1=0x00, dacq0/1=0, busy_mem=0, err=0 throughout.
- Write then read, LAT=2:
  - Core 0 writes 0xA5 to 0x10 (Mem_Ctrl0=4'b0010), sampled at t -> dacq0=1 at t+2 only.
  - Core 0 then reads 0x10 -> Ddin0=0xA5 with dacq0; busy_mem high t+1..t+3.
- Simultaneous requests after reset: core 0 reads 0x20 (holding 0x11), core 1 reads 0x21 (holding 0x22), both from the same cycle.
  - Core 0 is served first; core 1's dacq1 comes LAT+2 cycles after dacq0.
  - Ddin0=0x11, Ddin1=0x22.
  - With both cores continuously requesting, grants alternate 0,1,0,1.
- Illegal op: core 1 sends Mem_Ctrl1=4'b0011, address 0x05, data 0x3C -> err=1 and stays set; a subsequent read of 0x05 returns 0x3C.
- Reset mid-operation: RST asserted during WAIT of a write of 0x77 to 0x30 -> no dacq; a later read of 0x30 returns the prior value 0x00 (pre-written).
- LAT=1 and address wrap with DEPTH=16: a write to 0x13 then a read of 0x03 -> returns the written value; dacq one cycle after sampling; back-to-back acceptances 3 cycles apart.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Shared 8-bit data memory serving two cores, one transaction at a time.
//   Requests are arbitrated round-robin. Each granted request completes with a
//   one-cycle dacq pulse LAT cycles after it was sampled. One RECOVER cycle
//   follows every completion before the next request can be accepted.
//
// Parameters
//   DEPTH : number of 8-bit words (power of two, <= 256); upper address bits ignored
//   LAT   : cycles from acceptance to dacq (1..15)
//
// Ports
//   CLK, RST              : clock, synchronous active-high reset
//   Mem_Ctrl0/1  [3:0]    : bit0 = read, bit1 = write, bits 3:2 ignored
//   DAddress0/1  [7:0]    : data address
//   Ddout0/1     [7:0]    : write data from core
//   Ddin0/1      [7:0]    : read data to core, held until that port's next read
//   dacq0/1               : one-cycle completion pulse for the granted port
//   busy_mem              : high whenever a transaction is in progress
//   err                   : sticky, set when an accepted request has read and write both set

module data_mem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LAT   = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Mem_Ctrl0,
  input  logic [7:0] DAddress0,
  input  logic [7:0] Ddout0,
  output logic [7:0] Ddin0,
  output logic       dacq0,
  input  logic [3:0] Mem_Ctrl1,
  input  logic [7:0] DAddress1,
  input  logic [7:0] Ddout1,
  output logic [7:0] Ddin1,
  output logic       dacq1,
  output logic       busy_mem,
  output logic       err
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW     = 4;
  localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_grant;
  logic          w_grant_nxt;
  logic          r_last_grant;
  logic          r_wr;
  logic          w_wr_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic [7:0]    r_wdata;
  logic [7:0]    w_wdata_nxt;
  logic          w_set_err;

  logic          w_req0;
  logic          w_req1;
  logic [AW-1:0] w_addr0;
  logic [AW-1:0] w_addr1;
  logic          w_ack_nxt;
  logic          w_rd_nxt;
  logic          w_unused;

  logic [7:0]    r_mem [DEPTH];

  // Request decode; the effective address is the low AW bits (address mod DEPTH)
  assign w_req0  = |Mem_Ctrl0[1:0];
  assign w_req1  = |Mem_Ctrl1[1:0];
  assign w_addr0 = AW'(DAddress0);
  assign w_addr1 = AW'(DAddress1);

  // Control bits 3:2 (and any address bits above AW) carry no meaning here
  assign w_unused = ^{Mem_Ctrl0[3:2], Mem_Ctrl1[3:2], DAddress0, DAddress1};

  // Next-state and transaction-capture logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_wr_nxt    = r_wr;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_set_err   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_req0 || w_req1) begin
          // On a tie the port that was not served last wins
          w_grant_nxt = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
          if (w_grant_nxt) begin
            w_wr_nxt    = Mem_Ctrl1[1];
            w_addr_nxt  = w_addr1;
            w_wdata_nxt = Ddout1;
            w_set_err   = &Mem_Ctrl1[1:0];
          end else begin
            w_wr_nxt    = Mem_Ctrl0[1];
            w_addr_nxt  = w_addr0;
            w_wdata_nxt = Ddout0;
            w_set_err   = &Mem_Ctrl0[1:0];
          end
          w_cnt_nxt   = LAT_M1;
          w_state_nxt = (LAT_M1 == '0) ? ST_ACK : ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Counter was loaded with LAT-1, so WAIT lasts LAT-1 cycles
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      ST_ACK: begin
        w_state_nxt = ST_RECOVER;
      end

      ST_RECOVER: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are computed from the state being entered
  assign w_ack_nxt = (w_state_nxt == ST_ACK);
  assign w_rd_nxt  = w_ack_nxt & ~w_wr_nxt;

  // State, transaction registers and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      busy_mem     <= 1'b0;
      err          <= 1'b0;
      dacq0        <= 1'b0;
      dacq1        <= 1'b0;
      Ddin0        <= '0;
      Ddin1        <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_grant  <= w_grant_nxt;
      r_wr     <= w_wr_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      busy_mem <= (w_state_nxt != ST_IDLE);
      err      <= err | w_set_err;
      dacq0    <= w_ack_nxt & ~w_grant_nxt;
      dacq1    <= w_ack_nxt & w_grant_nxt;
      if (r_state == ST_ACK) begin
        r_last_grant <= r_grant;
      end
      // Read data lands together with dacq; writes leave Ddin untouched
      if (w_rd_nxt && !w_grant_nxt) begin
        Ddin0 <= r_mem[w_addr_nxt];
      end
      if (w_rd_nxt && w_grant_nxt) begin
        Ddin1 <= r_mem[w_addr_nxt];
      end
    end
  end

  // Storage is not cleared by reset; a write commits at the end of ACK and a
  // reset arriving at that edge suppresses it
  always_ff @(posedge CLK) begin
    if (!RST && (r_state == ST_ACK) && r_wr) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed and randomized checks of data_mem_responder against a
//   transaction-level model: a memory array, the last served port, the sticky
//   error flag and each port's last read value. A second instance with
//   DEPTH=16, LAT=1 covers single-cycle latency and address wrap.

module tb_data_mem_responder;

  localparam int LAT = 2;

  logic       CLK;
  logic       RST;
  logic [3:0] c0, c1;
  logic [7:0] a0, a1, o0, o1;
  logic [7:0] di0, di1;
  logic       dq0, dq1, busy, err;

  logic       s_rst;
  logic [3:0] s_c0, s_c1;
  logic [7:0] s_a0, s_a1, s_o0, s_o1;
  logic [7:0] s_di0, s_di1;
  logic       s_dq0, s_dq1, s_busy, s_err;

  int n_checks;
  int n_fail;

  logic [7:0] m_mem [256];
  logic [7:0] m_ddin [2];
  logic       m_last;
  logic       m_err;

  data_mem_responder #(.DEPTH(256), .LAT(LAT)) u_dut (
    .CLK(CLK), .RST(RST),
    .Mem_Ctrl0(c0), .DAddress0(a0), .Ddout0(o0), .Ddin0(di0), .dacq0(dq0),
    .Mem_Ctrl1(c1), .DAddress1(a1), .Ddout1(o1), .Ddin1(di1), .dacq1(dq1),
    .busy_mem(busy), .err(err)
  );

  data_mem_responder #(.DEPTH(16), .LAT(1)) u_small (
    .CLK(CLK), .RST(s_rst),
    .Mem_Ctrl0(s_c0), .DAddress0(s_a0), .Ddout0(s_o0), .Ddin0(s_di0), .dacq0(s_dq0),
    .Mem_Ctrl1(s_c1), .DAddress1(s_a1), .Ddout1(s_o1), .Ddin1(s_di1), .dacq1(s_dq1),
    .busy_mem(s_busy), .err(s_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk1({tag, "_dacq0"}, dq0, 1'b0);
    chk1({tag, "_dacq1"}, dq1, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_err"}, err, m_err);
    chk8({tag, "_Ddin0"}, di0, m_ddin[0]);
    chk8({tag, "_Ddin1"}, di1, m_ddin[1]);
  endtask

  task automatic do_reset();
    c0 = '0; c1 = '0;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    m_last    = 1'b1;
    m_err     = 1'b0;
    m_ddin[0] = 8'h00;
    m_ddin[1] = 8'h00;
  endtask

  // One step from an idle responder: up to one request per port, issued in
  // the same cycle. Expected timing: first transaction sampled at cycle 0,
  // dacq at LAT, idle again at LAT+2 where the second one is sampled.
  task automatic step(input logic [3:0] ctl0, input logic [7:0] ad0, input logic [7:0] dt0,
                      input logic [3:0] ctl1, input logic [7:0] ad1, input logic [7:0] dt1);
    logic [3:0] ctl [2];
    logic [7:0] ad [2];
    logic [7:0] dt [2];
    logic       vld [2];
    int         st_at [2];
    int         dq_at [2];
    int         first;
    int         endc;
    logic       exp_busy;
    logic       both;
    ctl[0] = ctl0; ad[0] = ad0; dt[0] = dt0;
    ctl[1] = ctl1; ad[1] = ad1; dt[1] = dt1;
    vld[0] = |ctl0[1:0];
    vld[1] = |ctl1[1:0];
    both   = vld[0] && vld[1];
    first  = both ? (m_last ? 0 : 1) : (vld[1] ? 1 : 0);
    st_at[first] = 0;
    dq_at[first] = LAT;
    if (both) begin
      st_at[1-first] = LAT + 2;
      dq_at[1-first] = 2*LAT + 2;
      endc = 2*LAT + 4;
    end else begin
      st_at[1-first] = -100;
      dq_at[1-first] = -100;
      endc = LAT + 2;
    end
    c0 = ctl0; a0 = ad0; o0 = dt0;
    c1 = ctl1; a1 = ad1; o1 = dt1;
    for (int k = 1; k <= endc; k++) begin
      tick();
      exp_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (vld[i] && k > st_at[i] && k <= st_at[i] + LAT + 1) exp_busy = 1'b1;
        if (vld[i] && k == st_at[i] + 1 && ctl[i][1:0] == 2'b11) m_err = 1'b1;
        if (vld[i] && k == dq_at[i]) begin
          if (ctl[i][1]) m_mem[ad[i]] = dt[i];
          else           m_ddin[i] = m_mem[ad[i]];
        end
      end
      chk1("dacq0", dq0, vld[0] && k == dq_at[0]);
      chk1("dacq1", dq1, vld[1] && k == dq_at[1]);
      chk8("Ddin0", di0, m_ddin[0]);
      chk8("Ddin1", di1, m_ddin[1]);
      chk1("busy_mem", busy, exp_busy);
      chk1("err", err, m_err);
      if (vld[0] && k == dq_at[0]) c0 = 4'h0;
      if (vld[1] && k == dq_at[1]) c1 = 4'h0;
    end
    m_last = both ? (first == 0) : (first == 1);
  endtask

  function automatic logic [3:0] rnd_ctl();
    int r;
    logic [1:0] op;
    r  = int'($urandom_range(0, 9));
    op = (r < 5) ? 2'b01 : ((r < 9) ? 2'b10 : 2'b11);
    return {2'($urandom), op};
  endfunction

  initial begin
    int mode;
    logic [3:0] rc0, rc1;
    n_checks = 0;
    n_fail   = 0;
    c0 = '0; c1 = '0; a0 = '0; a1 = '0; o0 = '0; o1 = '0;
    s_rst = 1'b1;
    s_c0 = '0; s_c1 = '0; s_a0 = '0; s_a1 = '0; s_o0 = '0; s_o1 = '0;
    RST = 1'b1;

    // Reset state, then ten idle cycles
    do_reset();
    chk_all("reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("idle");
    end

    // Write then read back on core 0
    step(4'b0010, 8'h10, 8'hA5, 4'h0, 8'h00, 8'h00);
    chk8("wr_keeps_Ddin0", di0, 8'h00);
    step(4'b0001, 8'h10, 8'h00, 4'h0, 8'h00, 8'h00);
    chk8("rd_0x10", di0, 8'hA5);

    // Simultaneous reads right after reset; core 0 wins the first tie
    step(4'b0010, 8'h20, 8'h11, 4'h0, 8'h00, 8'h00);
    step(4'h0, 8'h00, 8'h00, 4'b0010, 8'h21, 8'h22);
    do_reset();
    step(4'b0001, 8'h20, 8'h00, 4'b0001, 8'h21, 8'h00);
    chk8("sim_Ddin0", di0, 8'h11);
    chk8("sim_Ddin1", di1, 8'h22);
    step(4'b1001, 8'h21, 8'h00, 4'b0101, 8'h20, 8'h00);
    step(4'b0001, 8'h10, 8'h00, 4'b0001, 8'h10, 8'h00);
    chk8("alt_Ddin1", di1, 8'hA5);

    // Read and write both set: treated as a write, err sticks
    step(4'h0, 8'h00, 8'h00, 4'b0011, 8'h05, 8'h3C);
    chk1("err_set", err, 1'b1);
    step(4'h0, 8'h00, 8'h00, 4'b0001, 8'h05, 8'h00);
    chk8("rd_0x05", di1, 8'h3C);
    chk1("err_sticky", err, 1'b1);

    // Reset during WAIT aborts the write and the completion
    step(4'b0010, 8'h30, 8'h00, 4'h0, 8'h00, 8'h00);
    c0 = 4'b0010; a0 = 8'h30; o0 = 8'h77;
    tick();
    chk1("abort_busy", busy, 1'b1);
    chk1("abort_dacq_pre", dq0, 1'b0);
    RST = 1'b1;
    tick();
    chk1("abort_dacq0", dq0, 1'b0);
    chk1("abort_busy_rst", busy, 1'b0);
    chk1("abort_err_clr", err, 1'b0);
    c0 = '0;
    tick();
    chk1("abort_dacq0_2", dq0, 1'b0);
    RST = 1'b0;
    m_last = 1'b1; m_err = 1'b0; m_ddin[0] = 8'h00; m_ddin[1] = 8'h00;
    step(4'b0001, 8'h10, 8'h00, 4'h0, 8'h00, 8'h00);
    step(4'b0001, 8'h30, 8'h00, 4'h0, 8'h00, 8'h00);
    chk8("rd_0x30_prior", di0, 8'h00);

    // Randomized traffic over a pre-written address pool
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 0)
        step(4'b0010, 8'(8'h80 + i), 8'($urandom), 4'h0, 8'h00, 8'h00);
      else
        step(4'h0, 8'h00, 8'h00, 4'b0010, 8'(8'h80 + i), 8'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 2));
      rc0 = (mode != 1) ? rnd_ctl() : {2'($urandom), 2'b00};
      rc1 = (mode != 0) ? rnd_ctl() : {2'($urandom), 2'b00};
      step(rc0, 8'(8'h80 + $urandom_range(0, 15)), 8'($urandom),
           rc1, 8'(8'h80 + $urandom_range(0, 15)), 8'($urandom));
    end

    // LAT=1, DEPTH=16: write 0x13 wraps to 0x03
    tick();
    s_rst = 1'b0;
    chk1("s_reset_busy", s_busy, 1'b0);
    s_c0 = 4'b0010; s_a0 = 8'h13; s_o0 = 8'h5A;
    tick();
    chk1("s_wr_dacq", s_dq0, 1'b1);
    chk1("s_wr_busy", s_busy, 1'b1);
    chk8("s_wr_Ddin0", s_di0, 8'h00);
    s_c0 = 4'b0001; s_a0 = 8'h03;
    tick();
    chk1("s_recover_dacq", s_dq0, 1'b0);
    chk1("s_recover_busy", s_busy, 1'b1);
    tick();
    chk1("s_idle_dacq", s_dq0, 1'b0);
    chk1("s_idle_busy", s_busy, 1'b0);
    tick();
    chk1("s_rd_dacq", s_dq0, 1'b1);
    chk8("s_rd_wrap", s_di0, 8'h5A);
    chk1("s_rd_dacq1", s_dq1, 1'b0);
    s_c0 = '0;
    tick();
    chk1("s_end_dacq", s_dq0, 1'b0);
    chk1("s_err", s_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
